// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the multi-cycle RV32I core.
//   - FSM state enum, halt codes, major opcodes, EBREAK encoding
//   - load_extract(): selects and sign/zero-extends the loaded lane
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_IWAIT = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MREQ  = 3'd3,
        ST_MWAIT = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    localparam logic [1:0] HC_NONE     = 2'd0;
    localparam logic [1:0] HC_EBREAK   = 2'd1;
    localparam logic [1:0] HC_ILLEGAL  = 2'd2;
    localparam logic [1:0] HC_MISALIGN = 2'd3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    // Shift the addressed lane down to bit 0, then extend per the load width.
    function automatic logic [31:0] load_extract(input logic [2:0]  funct3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (funct3)
            3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_extract = {24'd0, sh[7:0]};
            3'b101:  load_extract = {16'd0, sh[15:0]};
            default: load_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/gpr_file.sv
// gpr_file: architectural register file, NR_REGS x 32 bits.
//   clk, rst (async active-low, clears all registers)
//   raddr1_i/rdata1_o, raddr2_i/rdata2_o : asynchronous read ports
//   we_i, waddr_i, wdata_i               : synchronous write port
// x0 and indices >= NR_REGS read as zero; writes to them are dropped.
module gpr_file
    import core_pkg::*;
#(
    parameter int NR_REGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    localparam int AW = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;

    logic [31:0] regs_q [NR_REGS];

    assign rdata1_o = (raddr1_i != 5'd0 && int'(raddr1_i) < NR_REGS) ? regs_q[raddr1_i[AW-1:0]] : 32'd0;
    assign rdata2_o = (raddr2_i != 5'd0 && int'(raddr2_i) < NR_REGS) ? regs_q[raddr2_i[AW-1:0]] : 32'd0;

    // Register storage: cleared on reset, one write per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_i && waddr_i != 5'd0 && int'(waddr_i) < NR_REGS) begin
            regs_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mc_core.sv
// mc_core: multi-cycle RV32I (+EBREAK) core, FSM FETCH/IWAIT/EXEC/MREQ/MWAIT/HALT.
//   clk, rst (async active-low)
//   imem_*  : fetch request/response handshake (addr = PC)
//   dmem_*  : data request/response handshake (word-aligned addr, byte strobes)
//   retire  : one-cycle pulse per completed instruction
//   pc_o    : PC of the instruction in flight (or next to fetch)
//   halted/halt_code : absorbing stop state and its cause
module mc_core
    import core_pkg::*;
#(
    parameter int          NR_REGS  = 16,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        retire,
    output logic [31:0] pc_o,
    output logic        halted,
    output logic [1:0]  halt_code
);

    state_e      state_q;
    logic [31:0] pc_q, ir_q, dmem_addr_q, dmem_wdata_q;
    logic        imem_req_valid_q, dmem_req_valid_q, dmem_we_q;
    logic [3:0]  dmem_wstrb_q;
    logic [1:0]  ea_lo_q, halt_code_q;

    // Instruction fields and immediates
    logic [6:0]  opcode_s, f7_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  f3_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, rs1_v_s, rs2_v_s;

    assign opcode_s = ir_q[6:0];
    assign rd_s     = ir_q[11:7];
    assign f3_s     = ir_q[14:12];
    assign rs1_s    = ir_q[19:15];
    assign rs2_s    = ir_q[24:20];
    assign f7_s     = ir_q[31:25];
    assign imm_i_s  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b_s  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u_s  = {ir_q[31:12], 12'd0};
    assign imm_j_s  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    logic [31:0] alu_s, ea_s, tgt_s, pc_next_s, wb_data_s, st_wdata_s;
    logic [3:0]  st_wstrb_s;
    logic        taken_s, illegal_s, misalign_s, is_mem_s, wb_en_s, ebreak_s;
    logic        use_rs1_s, use_rs2_s, use_rd_s;
    logic        gpr_we_s;
    logic [31:0] gpr_wdata_s;

    // ALU, branch compare and store lane formatting
    always_comb begin
        logic [31:0] op_b;
        op_b = (opcode_s == OPC_OP) ? rs2_v_s : imm_i_s;
        case (f3_s)
            3'b000:  alu_s = (opcode_s == OPC_OP && ir_q[30]) ? rs1_v_s - op_b : rs1_v_s + op_b;
            3'b001:  alu_s = rs1_v_s << op_b[4:0];
            3'b010:  alu_s = {31'd0, $signed(rs1_v_s) < $signed(op_b)};
            3'b011:  alu_s = {31'd0, rs1_v_s < op_b};
            3'b100:  alu_s = rs1_v_s ^ op_b;
            3'b101:  alu_s = ir_q[30] ? 32'($signed(rs1_v_s) >>> op_b[4:0]) : rs1_v_s >> op_b[4:0];
            3'b110:  alu_s = rs1_v_s | op_b;
            default: alu_s = rs1_v_s & op_b;
        endcase
        case (f3_s)
            3'b000:  taken_s = rs1_v_s == rs2_v_s;
            3'b001:  taken_s = rs1_v_s != rs2_v_s;
            3'b100:  taken_s = $signed(rs1_v_s) <  $signed(rs2_v_s);
            3'b101:  taken_s = $signed(rs1_v_s) >= $signed(rs2_v_s);
            3'b110:  taken_s = rs1_v_s <  rs2_v_s;
            3'b111:  taken_s = rs1_v_s >= rs2_v_s;
            default: taken_s = 1'b0;
        endcase
        ea_s = rs1_v_s + ((opcode_s == OPC_STORE) ? imm_s_s : imm_i_s);
        case (f3_s[1:0])
            2'b00: begin
                st_wdata_s = {4{rs2_v_s[7:0]}};
                st_wstrb_s = 4'b0001 << ea_s[1:0];
            end
            2'b01: begin
                st_wdata_s = {2{rs2_v_s[15:0]}};
                st_wstrb_s = 4'b0011 << ea_s[1:0];
            end
            default: begin
                st_wdata_s = rs2_v_s;
                st_wstrb_s = 4'b1111;
            end
        endcase
    end

    // Decode: legality, next PC, writeback value, alignment faults
    always_comb begin
        illegal_s = 1'b1;  misalign_s = 1'b0;  is_mem_s = 1'b0;  ebreak_s = 1'b0;
        wb_en_s   = 1'b0;  wb_data_s  = alu_s; tgt_s    = pc_q + imm_b_s;
        use_rs1_s = 1'b0;  use_rs2_s  = 1'b0;  use_rd_s = 1'b0;
        pc_next_s = pc_q + 32'd4;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: begin
                illegal_s = 1'b0; use_rd_s = 1'b1; wb_en_s = 1'b1;
                wb_data_s = (opcode_s == OPC_LUI) ? imm_u_s : pc_q + imm_u_s;
            end
            OPC_JAL, OPC_JALR: begin
                illegal_s = (opcode_s == OPC_JALR) && (f3_s != 3'd0);
                use_rs1_s = (opcode_s == OPC_JALR);
                use_rd_s  = 1'b1; wb_en_s = 1'b1; wb_data_s = pc_q + 32'd4;
                tgt_s     = (opcode_s == OPC_JAL) ? pc_q + imm_j_s : (rs1_v_s + imm_i_s) & ~32'd1;
                pc_next_s = tgt_s;
                misalign_s = tgt_s[1];
            end
            OPC_BRANCH: begin
                illegal_s = (f3_s[2:1] == 2'b01);
                use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                if (taken_s) begin
                    pc_next_s  = tgt_s;
                    misalign_s = tgt_s[1];
                end else begin
                    pc_next_s  = pc_q + 32'd4;
                end
            end
            OPC_LOAD, OPC_STORE: begin
                if (opcode_s == OPC_LOAD) begin
                    illegal_s = (f3_s == 3'd3) || (f3_s[2:1] == 2'b11);
                    use_rd_s  = 1'b1;
                end else begin
                    illegal_s = f3_s[2] || (f3_s[1:0] == 2'b11);
                    use_rs2_s = 1'b1;
                end
                use_rs1_s  = 1'b1; is_mem_s = 1'b1;
                misalign_s = (f3_s[1:0] == 2'b01 && ea_s[0]) || (f3_s[1:0] == 2'b10 && ea_s[1:0] != 2'b00);
            end
            OPC_OPIMM: begin
                illegal_s = (f3_s == 3'd1 && f7_s != 7'd0) ||
                            (f3_s == 3'd5 && f7_s != 7'd0 && f7_s != 7'b0100000);
                use_rs1_s = 1'b1; use_rd_s = 1'b1; wb_en_s = 1'b1;
            end
            OPC_OP: begin
                illegal_s = !(f7_s == 7'd0 || (f7_s == 7'b0100000 && (f3_s == 3'd0 || f3_s == 3'd5)));
                use_rs1_s = 1'b1; use_rs2_s = 1'b1; use_rd_s = 1'b1; wb_en_s = 1'b1;
            end
            OPC_SYSTEM: begin
                illegal_s = (ir_q != EBREAK_INSN);
                ebreak_s  = (ir_q == EBREAK_INSN);
            end
            default: illegal_s = 1'b1;
        endcase
        // Register indices beyond the implemented file make the encoding illegal.
        if ((use_rs1_s && int'(rs1_s) >= NR_REGS) || (use_rs2_s && int'(rs2_s) >= NR_REGS) ||
            (use_rd_s && int'(rd_s) >= NR_REGS)) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = illegal_s;
        end
    end

    // Writeback comes either from EXEC (ALU/jump/upper) or from MWAIT (load data).
    always_comb begin
        if (state_q == ST_MWAIT) begin
            gpr_we_s    = dmem_rsp_valid && !dmem_we_q;
            gpr_wdata_s = load_extract(f3_s, ea_lo_q, dmem_rdata);
        end else begin
            gpr_we_s    = (state_q == ST_EXEC) && wb_en_s && !illegal_s && !misalign_s;
            gpr_wdata_s = wb_data_s;
        end
    end

    gpr_file #(.NR_REGS(NR_REGS)) u_gpr (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (rs1_s),
        .rdata1_o (rs1_v_s),
        .raddr2_i (rs2_s),
        .rdata2_o (rs2_v_s),
        .we_i     (gpr_we_s),
        .waddr_i  (rd_s),
        .wdata_i  (gpr_wdata_s)
    );

    // Main control FSM with registered request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_FETCH;
            pc_q             <= RESET_PC;
            ir_q             <= 32'd0;
            imem_req_valid_q <= 1'b0;
            dmem_req_valid_q <= 1'b0;
            dmem_addr_q      <= 32'd0;
            dmem_we_q        <= 1'b0;
            dmem_wdata_q     <= 32'd0;
            dmem_wstrb_q     <= 4'd0;
            ea_lo_q          <= 2'd0;
            halt_code_q      <= HC_NONE;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // First cycle after reset only raises valid; address is already PC.
                    if (imem_req_valid_q && imem_req_ready) begin
                        imem_req_valid_q <= 1'b0;
                        state_q          <= ST_IWAIT;
                    end else begin
                        imem_req_valid_q <= 1'b1;
                    end
                end
                ST_IWAIT: begin
                    if (imem_rsp_valid) begin
                        ir_q    <= imem_rdata;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (illegal_s) begin
                        halt_code_q <= HC_ILLEGAL;
                        state_q     <= ST_HALT;
                    end else if (misalign_s) begin
                        halt_code_q <= HC_MISALIGN;
                        state_q     <= ST_HALT;
                    end else if (ebreak_s) begin
                        halt_code_q <= HC_EBREAK;
                        state_q     <= ST_HALT;
                    end else if (is_mem_s) begin
                        dmem_req_valid_q <= 1'b1;
                        dmem_addr_q      <= {ea_s[31:2], 2'b00};
                        dmem_we_q        <= (opcode_s == OPC_STORE);
                        dmem_wdata_q     <= (opcode_s == OPC_STORE) ? st_wdata_s : 32'd0;
                        dmem_wstrb_q     <= (opcode_s == OPC_STORE) ? st_wstrb_s : 4'd0;
                        ea_lo_q          <= ea_s[1:0];
                        state_q          <= ST_MREQ;
                    end else begin
                        pc_q             <= pc_next_s;
                        imem_req_valid_q <= 1'b1;
                        state_q          <= ST_FETCH;
                    end
                end
                ST_MREQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid_q <= 1'b0;
                        state_q          <= ST_MWAIT;
                    end
                end
                ST_MWAIT: begin
                    if (dmem_rsp_valid) begin
                        pc_q             <= pc_q + 32'd4;
                        imem_req_valid_q <= 1'b1;
                        state_q          <= ST_FETCH;
                    end
                end
                ST_HALT:  state_q <= ST_HALT;
                default: begin
                    halt_code_q <= HC_ILLEGAL;
                    state_q     <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_req_valid = imem_req_valid_q;
    assign imem_addr      = pc_q;
    assign dmem_req_valid = dmem_req_valid_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_wstrb     = dmem_wstrb_q;
    // Retire coincides with the completing cycle so pc_o still names that instruction.
    assign retire         = ((state_q == ST_EXEC) && !illegal_s && !misalign_s && !is_mem_s) ||
                            ((state_q == ST_MWAIT) && dmem_rsp_valid);
    assign pc_o           = pc_q;
    assign halted         = (state_q == ST_HALT);
    assign halt_code      = halt_code_q;

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core with zero-wait instruction/data memory models.
module tb_mc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        retire, halted;
    logic [31:0] pc_o;
    logic [1:0]  halt_code;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:15];
    logic        imem_ready_en, dmem_ready_en, dmem_rsp_en, clr_cnt;
    logic [31:0] st_addr = 32'd0, st_wdata = 32'd0;
    logic [3:0]  st_wstrb = 4'd0;
    logic        st_we = 1'b0;
    int          dreq_cycles = 0;
    int          n_cmp, n_fail;

    always #5 clk = ~clk;

    assign imem_req_ready = imem_ready_en;
    assign dmem_req_ready = dmem_ready_en;

    mc_core dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
        .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .retire(retire), .pc_o(pc_o), .halted(halted), .halt_code(halt_code)
    );

    // Memory responders: response one cycle after acceptance; stores are logged, not written.
    always @(posedge clk) begin
        imem_rsp_valid <= imem_req_valid && imem_req_ready;
        imem_rdata     <= imem[imem_addr[7:2]];
        dmem_rsp_valid <= dmem_req_valid && dmem_req_ready && dmem_rsp_en;
        dmem_rdata     <= dmem[dmem_addr[5:2]];
        if (clr_cnt) dreq_cycles <= 0;
        else if (dmem_req_valid) dreq_cycles <= dreq_cycles + 1;
        if (dmem_req_valid && dmem_req_ready) begin
            st_addr  <= dmem_addr;
            st_we    <= dmem_we;
            st_wdata <= dmem_wdata;
            st_wstrb <= dmem_wstrb;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clr_cnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        clr_cnt = 1'b0;
    endtask

    task automatic wait_retire(input string tag, output int cycles);
        int n;
        bit got;
        n = 0; got = 1'b0; cycles = 0;
        while (!got && n < 40) begin
            step();
            n++;
            if (retire === 1'b1) begin
                got = 1'b1;
                cycles = n;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $error("FAIL %s: observed no retire expected retire within 40 cycles", tag);
        end
    endtask

    task automatic wait_halt(input string tag, output int retires);
        int n;
        n = 0; retires = 0;
        while (halted !== 1'b1 && n < 200) begin
            step();
            n++;
            if (retire === 1'b1) retires++;
        end
        if (halted !== 1'b1) begin
            n_cmp++; n_fail++;
            $error("FAIL %s: observed no halt expected halt within 200 cycles", tag);
        end
    endtask

    initial begin
        int c, r, k;
        n_cmp = 0; n_fail = 0;
        rst = 1'b0; clr_cnt = 1'b1;
        imem_ready_en = 1'b1; dmem_ready_en = 1'b1; dmem_rsp_en = 1'b1;
        for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
        dmem[0] = 32'h0000_8000;

        // Program 1: addi / add / sw / lb / ebreak
        clear_imem();
        imem[0] = 32'h0050_0093;  // addi x1,x0,5
        imem[1] = 32'h0010_8133;  // add  x2,x1,x1
        imem[2] = 32'h0020_2023;  // sw   x2,0(x0)
        imem[3] = 32'h0010_0183;  // lb   x3,1(x0)
        imem[4] = 32'h0010_0073;  // ebreak
        rst = 1'b0;
        step();
        check("rst_imem_valid", imem_req_valid, 1'b0);
        check("rst_dmem_valid", dmem_req_valid, 1'b0);
        check("rst_retire", retire, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_halt_code", halt_code, 2'd0);
        check("rst_pc", pc_o, 32'h8000_0000);
        do_reset();
        wait_retire("p1_addi", c);
        check("p1_addi_cycles", c, 32'd3);
        check("p1_addi_pc", pc_o, 32'h8000_0000);
        wait_retire("p1_add", c);
        check("p1_add_cycles", c, 32'd3);
        check("p1_add_pc", pc_o, 32'h8000_0004);
        check("p1_x1", dut.u_gpr.regs_q[1], 32'd5);
        wait_retire("p1_sw", c);
        check("p1_sw_cycles", c, 32'd5);
        check("p1_x2", dut.u_gpr.regs_q[2], 32'd10);
        check("p1_sw_addr", st_addr, 32'd0);
        check("p1_sw_we", st_we, 1'b1);
        check("p1_sw_wstrb", st_wstrb, 4'b1111);
        check("p1_sw_wdata", st_wdata, 32'd10);
        wait_retire("p1_lb", c);
        check("p1_lb_cycles", c, 32'd5);
        check("p1_lb_pc", pc_o, 32'h8000_000C);
        check("p1_lb_we", st_we, 1'b0);
        check("p1_lb_wstrb", st_wstrb, 4'b0000);
        wait_retire("p1_ebreak", c);
        check("p1_ebreak_pc", pc_o, 32'h8000_0010);
        check("p1_x3", dut.u_gpr.regs_q[3], 32'hFFFF_FF80);
        step();
        check("p1_halted", halted, 1'b1);
        check("p1_halt_code", halt_code, 2'd1);
        repeat (3) step();
        check("p1_halt_no_fetch", imem_req_valid, 1'b0);
        check("p1_halt_pc", pc_o, 32'h8000_0010);

        // Program 2: fetch stall, ALU mix, x0 write, jal skipping an illegal word
        clear_imem();
        imem[0]  = 32'hFFF0_0293;  // addi x5,x0,-1
        imem[1]  = 32'hFF00_0313;  // addi x6,x0,-16
        imem[2]  = 32'h4023_5393;  // srai x7,x6,2
        imem[3]  = 32'h01C3_5413;  // srli x8,x6,28
        imem[4]  = 32'h0050_34B3;  // sltu x9,x0,x5
        imem[5]  = 32'h0002_A533;  // slt  x10,x5,x0
        imem[6]  = 32'h4050_05B3;  // sub  x11,x0,x5
        imem[7]  = 32'h1234_5637;  // lui  x12,0x12345
        imem[8]  = 32'h0050_0013;  // addi x0,x0,5
        imem[9]  = 32'h0080_06EF;  // jal  x13,+8
        imem[10] = 32'h0000_0000;  // skipped
        imem[11] = 32'h0010_0073;  // ebreak
        imem_ready_en = 1'b0;
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            check("p2_stall_addr", imem_addr, 32'h8000_0000);
            check("p2_stall_retire", retire, 1'b0);
            check("p2_stall_valid", imem_req_valid, 1'b1);
            step();
        end
        imem_ready_en = 1'b1;
        wait_retire("p2_first", c);
        check("p2_first_pc", pc_o, 32'h8000_0000);
        wait_halt("p2_halt", r);
        check("p2_retires", r, 32'd10);
        check("p2_halt_code", halt_code, 2'd1);
        check("p2_halt_pc", pc_o, 32'h8000_002C);
        check("p2_x0", dut.u_gpr.regs_q[0], 32'd0);
        check("p2_x5", dut.u_gpr.regs_q[5], 32'hFFFF_FFFF);
        check("p2_x6", dut.u_gpr.regs_q[6], 32'hFFFF_FFF0);
        check("p2_x7_srai", dut.u_gpr.regs_q[7], 32'hFFFF_FFFC);
        check("p2_x8_srli", dut.u_gpr.regs_q[8], 32'h0000_000F);
        check("p2_x9_sltu", dut.u_gpr.regs_q[9], 32'd1);
        check("p2_x10_slt", dut.u_gpr.regs_q[10], 32'd1);
        check("p2_x11_sub", dut.u_gpr.regs_q[11], 32'd1);
        check("p2_x12_lui", dut.u_gpr.regs_q[12], 32'h1234_5000);
        check("p2_x13_jal", dut.u_gpr.regs_q[13], 32'h8000_0028);

        // Program 3: rd index beyond NR_REGS=16
        clear_imem();
        imem[0] = 32'h0070_0093;  // addi x1,x0,7
        imem[1] = 32'h0010_0A13;  // addi x20,x0,1
        do_reset();
        wait_halt("p3_halt", r);
        check("p3_retires", r, 32'd1);
        check("p3_halt_code", halt_code, 2'd2);
        check("p3_pc", pc_o, 32'h8000_0004);
        check("p3_x1", dut.u_gpr.regs_q[1], 32'd7);
        check("p3_x4_untouched", dut.u_gpr.regs_q[4], 32'd0);

        // Program 4: misaligned lw
        clear_imem();
        imem[0] = 32'h0020_2083;  // lw x1,2(x0)
        do_reset();
        wait_halt("p4_halt", r);
        repeat (2) step();
        check("p4_retires", r, 32'd0);
        check("p4_halt_code", halt_code, 2'd3);
        check("p4_no_dmem_req", dreq_cycles, 32'd0);
        check("p4_x1", dut.u_gpr.regs_q[1], 32'd0);

        // Program 5: reset asserted while waiting for load data
        clear_imem();
        imem[0] = 32'h0030_0093;  // addi x1,x0,3
        imem[1] = 32'h0000_2103;  // lw   x2,0(x0)
        dmem_rsp_en = 1'b0;
        do_reset();
        wait_retire("p5_addi", c);
        k = 0;
        while (dmem_req_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("p5_dmem_req_seen", dmem_req_valid, 1'b1);
        step();
        check("p5_x1_before", dut.u_gpr.regs_q[1], 32'd3);
        #2 rst = 1'b0;
        #1;
        check("p5_rst_imem_valid", imem_req_valid, 1'b0);
        check("p5_rst_dmem_valid", dmem_req_valid, 1'b0);
        check("p5_rst_pc", pc_o, 32'h8000_0000);
        check("p5_rst_x1", dut.u_gpr.regs_q[1], 32'd0);
        dmem_rsp_en = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("p5_refetch_valid", imem_req_valid, 1'b1);
        check("p5_refetch_addr", imem_addr, 32'h8000_0000);
        wait_retire("p5_again", c);
        check("p5_again_cycles", c, 32'd2);
        check("p5_again_pc", pc_o, 32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
